arp_tx: RTL and testbench
=========================

// Module: arp_tx
// PURPOSE
//  ARP frame transmitter; consumes arp_rx results (src_ip/src_mac/type) via the ARP control layer.
//  On a start pulse, emits one complete Ethernet II ARP request or reply on GMII:
//  preamble/SFD, header, 28-byte ARP body, 18-byte zero pad and CRC-32 FCS.
//  Sits between the ARP control logic and the GMII TX mux, sharing the GMII clock domain with arp_rx.
// PARAMETERS
//  BOARD_MAC  48'h00_0a_35_01_fe_c0  local MAC; Ethernet source MAC and ARP sender MAC
//  BOARD_IP   32'hC0_A8_00_02        local IP; ARP sender IP
// PORTS
//  clk           in   1   GMII TX clock; only clock
//  rst           in   1   asynchronous, active-low reset
//  arp_tx_en     in   1   start pulse; sampled only in IDLE
//  arp_tx_type   in   1   0 = request, 1 = reply; latched with arp_tx_en
//  des_mac       in   48  target MAC (reply only); latched with arp_tx_en
//  des_ip        in   32  target IP; latched with arp_tx_en
//  gmii_tx_en    out  1   GMII transmit enable
//  gmii_txd      out  8   GMII transmit data
//  tx_busy       out  1   high from start acceptance until ready for next start
//  tx_done       out  1   one-cycle pulse after the last FCS byte
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  - Reset: gmii_tx_en=0, gmii_txd=8'h00, tx_busy=0, tx_done=0, FSM=IDLE, byte cnt=0, CRC=32'hFFFFFFFF.
//  - Reset mid-frame: outputs forced to reset values immediately; frame is abandoned and not resumed.
//  - FSM: IDLE -> PREAMBLE -> ETH_HEAD -> ARP_DATA -> CRC -> IFG -> IDLE.
//  - IDLE: when arp_tx_en=1, latch type/des_mac/des_ip and set tx_busy=1.
//    gmii_tx_en rises next cycle (start latency 1 clk).
//  - Frame: 72 bytes, gmii_tx_en high for exactly 72 consecutive cycles, no gaps.
//    PREAMBLE   bytes 0-6 = 8'h55; byte 7 = 8'hD5.
//    ETH_HEAD   bytes 8-13 dest MAC: request = FF..FF, reply = latched des_mac.
//               bytes 14-19 BOARD_MAC; bytes 20-21 = 08 06.
//    ARP_DATA   00 01 | 08 00 | 06 | 04 | op 00 01 (request) or 00 02 (reply) | BOARD_MAC | BOARD_IP |
//               target MAC (request = 00..00, reply = des_mac) | des_ip | then 18 bytes 8'h00 pad.
//    CRC        4 FCS bytes.
//    All multi-byte fields are sent MSB byte first.
//  - CRC-32 (IEEE 802.3, poly 04C11DB7, reflected, byte-wise):
//    init FFFFFFFF at each start; updated on bytes 8..67 only.
//    FCS = ~crc, sent low byte first (bits [7:0] first).
//  - tx_done: one pulse in the cycle after byte 71, with gmii_tx_en already 0.
//  - IFG: 12 idle cycles after byte 71 with tx_busy=1; tx_busy drops as the FSM returns to IDLE.
//  - Start handling: arp_tx_en while tx_busy=1 is ignored (not queued).
//    Inputs are latched, so des_mac/des_ip/arp_tx_type may change mid-frame without effect.
//  - Byte counter is 7 bits; it clears at each state exit and never wraps within a state.
// CONFIGURATION
//  ARP_TX_IFG_EN defined: IFG state present; next start is accepted no earlier than 13 clk after byte 71.
//  ARP_TX_IFG_EN undefined: CRC -> IDLE directly; tx_busy drops in the tx_done cycle, and a start
//    in that same cycle is accepted (back-to-back frames, 1-cycle gap).
// TESTING
//  1 Request, des_ip=C0A80003 -> 72-byte frame: bytes 0-6=55, byte 7=D5, 8-13=FF, 20-21=0806, op=0001,
//    target MAC=0, target IP=C0 A8 00 03, pad=00, FCS equals a model CRC over bytes 8..67.
//  2 Reply, des_mac=11_22_33_44_55_66, des_ip=C0A80064 -> dest MAC and target MAC=11..66, op=0002, FCS correct.
//  3 arp_tx_en pulsed at byte 30 and in the tx_done cycle (ARP_TX_IFG_EN) -> both ignored;
//    start 13 clk after byte 71 is accepted.
//  4 rst low at byte 40 -> gmii_tx_en=0 the same cycle, no tx_done;
//    after release a start produces a full, correct frame.
//  5 Change des_ip/arp_tx_type mid-frame -> frame contents unchanged;
//    two back-to-back requests (C0A80003, C0A80004) produce distinct, correct FCS values.
//  6 ARP_TX_IFG_EN undefined, start held high continuously -> frames repeat with exactly 1 idle cycle between them.

Source files
------------

// File: rtl/arp_tx.sv
// arp_tx: sends one Ethernet II ARP request or reply on GMII per start pulse, with preamble, pad and CRC-32 FCS.
// Optional ARP_TX_IFG_EN adds a 12-cycle inter-frame gap before the next start can be accepted.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_0a_35_01_fe_c0,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_00_02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    ETH_HEAD = 3'd2,
    ARP_DATA = 3'd3,
    CRC      = 3'd4,
    IFG      = 3'd5
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [6:0]  cnt_r, cnt_nxt_s;
  logic [31:0] crc_r, crc_nxt_s, fcs_s;
  logic [7:0]  txd_nxt_s;
  logic        type_r;
  logic [47:0] mac_r;
  logic [31:0] ip_r;
  logic        tx_en_r, tx_busy_r, tx_done_r;
  logic [7:0]  txd_r;

  // Reflected IEEE 802.3 CRC-32, one byte folded in LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [6:0] idx);
    case (idx)
      7'd0:    byte_of48 = v[47:40];
      7'd1:    byte_of48 = v[39:32];
      7'd2:    byte_of48 = v[31:24];
      7'd3:    byte_of48 = v[23:16];
      7'd4:    byte_of48 = v[15:8];
      7'd5:    byte_of48 = v[7:0];
      default: byte_of48 = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input logic [6:0] idx);
    case (idx)
      7'd0:    byte_of32 = v[31:24];
      7'd1:    byte_of32 = v[23:16];
      7'd2:    byte_of32 = v[15:8];
      7'd3:    byte_of32 = v[7:0];
      default: byte_of32 = 8'h00;
    endcase
  endfunction

  // Next state and per-state byte counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + 7'd1;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 7'd0;
        if (arp_tx_en) state_nxt_s = PREAMBLE;
        else           state_nxt_s = IDLE;
      end
      PREAMBLE: begin
        if (cnt_r == 7'd7) begin state_nxt_s = ETH_HEAD; cnt_nxt_s = 7'd0; end
        else               state_nxt_s = PREAMBLE;
      end
      ETH_HEAD: begin
        if (cnt_r == 7'd13) begin state_nxt_s = ARP_DATA; cnt_nxt_s = 7'd0; end
        else                state_nxt_s = ETH_HEAD;
      end
      ARP_DATA: begin
        if (cnt_r == 7'd45) begin state_nxt_s = CRC; cnt_nxt_s = 7'd0; end
        else                state_nxt_s = ARP_DATA;
      end
      CRC: begin
`ifdef ARP_TX_IFG_EN
        if (cnt_r == 7'd3) begin state_nxt_s = IFG; cnt_nxt_s = 7'd0; end
`else
        if (cnt_r == 7'd3) begin state_nxt_s = IDLE; cnt_nxt_s = 7'd0; end
`endif
        else               state_nxt_s = CRC;
      end
`ifdef ARP_TX_IFG_EN
      IFG: begin
        if (cnt_r == 7'd11) begin state_nxt_s = IDLE; cnt_nxt_s = 7'd0; end
        else                state_nxt_s = IFG;
      end
`endif
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 7'd0;
      end
    endcase
  end

  assign fcs_s = ~crc_r;

  // Byte that goes on the wire in the next cycle, chosen from the upcoming state and count
  always_comb begin
    txd_nxt_s = 8'h00;
    case (state_nxt_s)
      PREAMBLE: txd_nxt_s = (cnt_nxt_s == 7'd7) ? 8'hD5 : 8'h55;
      ETH_HEAD: begin
        if (cnt_nxt_s < 7'd6)       txd_nxt_s = type_r ? byte_of48(mac_r, cnt_nxt_s) : 8'hFF;
        else if (cnt_nxt_s < 7'd12) txd_nxt_s = byte_of48(BOARD_MAC, cnt_nxt_s - 7'd6);
        else if (cnt_nxt_s == 7'd12) txd_nxt_s = 8'h08;
        else                        txd_nxt_s = 8'h06;
      end
      ARP_DATA: begin
        case (cnt_nxt_s)
          7'd0: txd_nxt_s = 8'h00;
          7'd1: txd_nxt_s = 8'h01;
          7'd2: txd_nxt_s = 8'h08;
          7'd3: txd_nxt_s = 8'h00;
          7'd4: txd_nxt_s = 8'h06;
          7'd5: txd_nxt_s = 8'h04;
          7'd6: txd_nxt_s = 8'h00;
          7'd7: txd_nxt_s = type_r ? 8'h02 : 8'h01;
          default: begin
            if (cnt_nxt_s < 7'd14)      txd_nxt_s = byte_of48(BOARD_MAC, cnt_nxt_s - 7'd8);
            else if (cnt_nxt_s < 7'd18) txd_nxt_s = byte_of32(BOARD_IP, cnt_nxt_s - 7'd14);
            else if (cnt_nxt_s < 7'd24) txd_nxt_s = type_r ? byte_of48(mac_r, cnt_nxt_s - 7'd18) : 8'h00;
            else if (cnt_nxt_s < 7'd28) txd_nxt_s = byte_of32(ip_r, cnt_nxt_s - 7'd24);
            else                        txd_nxt_s = 8'h00;
          end
        endcase
      end
      // FCS goes out least significant byte first
      CRC: begin
        case (cnt_nxt_s[1:0])
          2'd0:    txd_nxt_s = fcs_s[7:0];
          2'd1:    txd_nxt_s = fcs_s[15:8];
          2'd2:    txd_nxt_s = fcs_s[23:16];
          2'd3:    txd_nxt_s = fcs_s[31:24];
          default: txd_nxt_s = 8'h00;
        endcase
      end
      default: txd_nxt_s = 8'h00;
    endcase
  end

  // CRC restarts while idle and absorbs every header and ARP/pad byte as it is launched
  always_comb begin
    if (state_r == IDLE) begin
      crc_nxt_s = 32'hFFFFFFFF;
    end else if (state_nxt_s == ETH_HEAD || state_nxt_s == ARP_DATA) begin
      crc_nxt_s = crc32_byte(crc_r, txd_nxt_s);
    end else begin
      crc_nxt_s = crc_r;
    end
  end

  // FSM, counter, CRC and registered GMII/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 7'd0;
      crc_r     <= 32'hFFFFFFFF;
      tx_en_r   <= 1'b0;
      txd_r     <= 8'h00;
      tx_busy_r <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      crc_r     <= crc_nxt_s;
      tx_en_r   <= (state_nxt_s == PREAMBLE) || (state_nxt_s == ETH_HEAD) ||
                   (state_nxt_s == ARP_DATA) || (state_nxt_s == CRC);
      txd_r     <= txd_nxt_s;
      tx_busy_r <= (state_nxt_s != IDLE);
      tx_done_r <= (state_r == CRC) && (cnt_r == 7'd3);
    end
  end

  // Frame parameters are captured only when a start is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_r <= 1'b0;
      mac_r  <= 48'h0;
      ip_r   <= 32'h0;
    end else if (state_r == IDLE && arp_tx_en) begin
      type_r <= arp_tx_type;
      mac_r  <= des_mac;
      ip_r   <= des_ip;
    end else begin
      type_r <= type_r;
      mac_r  <= mac_r;
      ip_r   <= ip_r;
    end
  end

  assign gmii_tx_en = tx_en_r;
  assign gmii_txd   = txd_r;
  assign tx_busy    = tx_busy_r;
  assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx: frames are compared byte by byte with a field-level frame model.
`timescale 1ns/1ps
module tb_arp_tx;
  localparam logic [47:0] BOARD_MAC = 48'h00_0a_35_01_fe_c0;
  localparam logic [31:0] BOARD_IP  = 32'hC0_A8_00_02;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arp_tx_en = 1'b0;
  logic        arp_tx_type = 1'b0;
  logic [47:0] des_mac = 48'h0;
  logic [31:0] des_ip = 32'h0;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] fcs_a, fcs_b, fcs_tmp;

  always #4 clk = ~clk;

  arp_tx dut (
    .clk        (clk),
    .rst        (rst),
    .arp_tx_en  (arp_tx_en),
    .arp_tx_type(arp_tx_type),
    .des_mac    (des_mac),
    .des_ip     (des_ip),
    .gmii_tx_en (gmii_tx_en),
    .gmii_txd   (gmii_txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [47:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(v[8*k +: 8]);
  endtask

  // Expected frame assembled from its fields; FCS from a bit-serial CRC over bytes 8..67
  task automatic build_frame(input logic t, input logic [47:0] mac, input logic [31:0] ip);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic        fb;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    put(t ? mac : 48'hFFFF_FFFF_FFFF, 6);
    put(BOARD_MAC, 6);
    put(48'h0806, 2);
    put(48'h0001, 2);
    put(48'h0800, 2);
    put(48'h06, 1);
    put(48'h04, 1);
    put(t ? 48'h0002 : 48'h0001, 2);
    put(BOARD_MAC, 6);
    put({16'h0, BOARD_IP}, 4);
    put(t ? mac : 48'h0, 6);
    put({16'h0, ip}, 4);
    repeat (18) exp_q.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < 68; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb  = exp_q[i][b] ^ crc[0];
        crc = {1'b0, crc[31:1]};
        if (fb) crc = crc ^ 32'hEDB8_8320;
      end
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
  endtask

  // Starts a frame at the current falling edge and checks all 72 bytes plus the tx_done cycle
  task automatic run_frame(input logic t, input logic [47:0] mac, input logic [31:0] ip,
                           input int pulse_at, input int abort_at, input bit hold,
                           output logic [31:0] got_fcs);
    got_fcs = 32'h0;
    build_frame(t, mac, ip);
    arp_tx_type = t;
    des_mac     = mac;
    des_ip      = ip;
    arp_tx_en   = 1'b1;
    @(negedge clk);
    if (!hold) arp_tx_en = 1'b0;
    for (int i = 0; i < 72; i++) begin
      check($sformatf("tx_en[%0d]", i), 48'(gmii_tx_en), 48'd1);
      check($sformatf("byte[%0d]", i), 48'(gmii_txd), 48'(exp_q[i]));
      check($sformatf("busy[%0d]", i), 48'({tx_busy, tx_done}), 48'd2);
      if (i >= 68) got_fcs[8*(i-68) +: 8] = gmii_txd;
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_tx_en", 48'(gmii_tx_en), 48'd0);
        check("abort_txd", 48'(gmii_txd), 48'd0);
        check("abort_busy", 48'(tx_busy), 48'd0);
        repeat (3) begin
          @(negedge clk);
          check("abort_done", 48'({gmii_tx_en, tx_done}), 48'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle", 48'({gmii_tx_en, tx_busy, tx_done}), 48'd0);
        return;
      end
      if (i == pulse_at) begin
        arp_tx_en   = 1'b1;
        arp_tx_type = ~arp_tx_type;
        des_mac     = {16'($urandom), 32'($urandom)};
        des_ip      = 32'($urandom);
      end
      if (pulse_at >= 0 && i == pulse_at + 1) arp_tx_en = 1'b0;
      @(negedge clk);
    end
    check("fcs", 48'(got_fcs), 48'({exp_q[71], exp_q[70], exp_q[69], exp_q[68]}));
    check("post_tx_en", 48'(gmii_tx_en), 48'd0);
    check("tx_done", 48'(tx_done), 48'd1);
`ifdef ARP_TX_IFG_EN
    check("done_busy", 48'(tx_busy), 48'd1);
`else
    check("done_busy", 48'(tx_busy), 48'd0);
`endif
  endtask

  // Walks from the tx_done cycle to the first cycle a new start may be accepted
  task automatic ifg_wait(input bit pulse_done);
`ifdef ARP_TX_IFG_EN
    if (pulse_done) arp_tx_en = 1'b1;
    @(negedge clk);
    arp_tx_en = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      check($sformatf("ifg[%0d]", k), 48'({tx_busy, gmii_tx_en, tx_done}), 48'd4);
      @(negedge clk);
    end
    check("ifg_end", 48'({tx_busy, gmii_tx_en, tx_done}), 48'd0);
`else
    if (pulse_done) arp_tx_en = 1'b0;
    check("idle_gap", 48'({tx_busy, gmii_tx_en}), 48'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_en", 48'(gmii_tx_en), 48'd0);
    check("rst_txd", 48'(gmii_txd), 48'd0);
    check("rst_busy", 48'(tx_busy), 48'd0);
    check("rst_done", 48'(tx_done), 48'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle", 48'({gmii_tx_en, tx_busy, tx_done}), 48'd0);

    run_frame(1'b0, 48'h0, 32'hC0A80003, -1, -1, 1'b0, fcs_tmp);
    ifg_wait(1'b0);
    run_frame(1'b1, 48'h11_22_33_44_55_66, 32'hC0A80064, -1, -1, 1'b0, fcs_tmp);
    ifg_wait(1'b0);
    // start and field changes mid-frame, and a start in the tx_done cycle
    run_frame(1'b0, 48'hA1A2A3A4A5A6, 32'hC0A80010, 30, -1, 1'b0, fcs_tmp);
    ifg_wait(1'b1);
    run_frame(1'b1, 48'h0102030405AB, 32'hC0A80020, 30, -1, 1'b0, fcs_tmp);
    ifg_wait(1'b1);
    // reset in the middle of a frame, then a clean frame
    run_frame(1'b1, 48'hDEADBEEF0001, 32'hC0A80030, -1, 40, 1'b0, fcs_tmp);
    run_frame(1'b0, 48'h0, 32'hC0A80003, -1, -1, 1'b0, fcs_a);
    ifg_wait(1'b0);
    run_frame(1'b0, 48'h0, 32'hC0A80004, -1, -1, 1'b0, fcs_b);
    ifg_wait(1'b0);
    check("fcs_distinct", 48'(fcs_a != fcs_b), 48'd1);

    for (int n = 0; n < 6; n++) begin
      run_frame(1'($urandom_range(1, 0)), {16'($urandom), 32'($urandom)}, 32'($urandom),
                -1, -1, 1'b0, fcs_tmp);
      ifg_wait(1'b0);
    end

`ifndef ARP_TX_IFG_EN
    // start held high: frames repeat with one idle cycle between them
    for (int n = 0; n < 3; n++) begin
      run_frame(1'($urandom_range(1, 0)), {16'($urandom), 32'($urandom)}, 32'($urandom),
                -1, -1, 1'b1, fcs_tmp);
    end
    arp_tx_en = 1'b0;
    @(negedge clk);
    check("hold_end", 48'({gmii_tx_en, tx_busy}), 48'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
